// File: rtl/shift_cmd_encoder.sv
// Host-side producer for the shift-processing stream: programs the shift amount,
// pushes direction/data/end command words, drains results and waits for the done flag.
module shift_cmd_encoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmd_dir,
    input  logic [4:0]       shamt,
    input  logic [CNT_W-1:0] word_count,
    input  logic             src_valid,
    input  logic [27:0]      src_data,
    output logic             src_ready,
    output logic             wrreq,
    output logic [31:0]      wdata,
    input  logic             wrfull,
    output logic             rdack,
    input  logic [31:0]      rdata,
    input  logic             rdempty,
    output logic             res_valid,
    output logic [31:0]      res_data,
    output logic             reg_write,
    output logic [31:0]      reg_addr,
    output logic [31:0]      reg_wdata,
    input  logic [31:0]      reg_rdata,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [2:0]       dbg_state
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [3:0]  OP_RIGHT  = 4'b0001;
    localparam logic [3:0]  OP_LEFT   = 4'b0010;
    localparam logic [3:0]  OP_END    = 4'b0100;
    localparam logic [3:0]  OP_DATA   = 4'b1000;

    localparam logic [31:0] REG_RSHIFT = 32'd2;
    localparam logic [31:0] REG_LSHIFT = 32'd3;
    localparam logic [31:0] REG_FLAG   = 32'd4;
    localparam logic [31:0] DONE_FLAG  = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SET_SHAMT = 3'd1,
        S_CLR_FLAG  = 3'd2,
        S_SEND_DIR  = 3'd3,
        S_SEND_DATA = 3'd4,
        S_SEND_END  = 3'd5,
        S_WAIT_DONE = 3'd6,
        S_FINISH    = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic               dir_q, dir_d;
    logic [4:0]         shamt_q, shamt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   data_cnt_q, data_cnt_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               flag_q, flag_d;
    logic               timeout_q, timeout_d;
    logic               draining;
    logic               flag_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            shamt_q    <= 5'd0;
            count_q    <= '0;
            data_cnt_q <= '0;
            res_cnt_q  <= '0;
            wait_cnt_q <= '0;
            flag_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            shamt_q    <= shamt_d;
            count_q    <= count_d;
            data_cnt_q <= data_cnt_d;
            res_cnt_q  <= res_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            flag_q     <= flag_d;
            timeout_q  <= timeout_d;
        end
    end

    // Results are drained from the moment a job is accepted until it finishes,
    // so the slave never stalls on a full result FIFO.
    assign draining  = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign flag_now  = flag_q | (reg_rdata == DONE_FLAG);
    assign busy      = (state_q != S_IDLE);
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

    // Handshakes: a command word transfers on a cycle with wrreq=1 (never while
    // wrfull=1); a source word transfers when src_valid=1 and src_ready=1; a
    // result transfers on rdack=1, which is only raised while rdempty=0.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        shamt_d    = shamt_q;
        count_d    = count_q;
        data_cnt_d = data_cnt_q;
        res_cnt_d  = res_cnt_q;
        wait_cnt_d = wait_cnt_q;
        flag_d     = flag_q;
        timeout_d  = timeout_q;
        src_ready  = 1'b0;
        wrreq      = 1'b0;
        wdata      = 32'h0;
        rdack      = 1'b0;
        res_valid  = 1'b0;
        res_data   = 32'h0;
        reg_write  = 1'b0;
        reg_addr   = REG_FLAG;
        reg_wdata  = 32'h0;
        done       = 1'b0;

        if (draining) begin
            rdack     = ~rdempty;
            res_valid = ~rdempty;
            res_data  = rdata;
            if (!rdempty && (res_cnt_q != '1)) begin
                res_cnt_d = res_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dir_d      = cmd_dir;
                    shamt_d    = shamt;
                    count_d    = word_count;
                    data_cnt_d = '0;
                    res_cnt_d  = '0;
                    wait_cnt_d = '0;
                    flag_d     = 1'b0;
                    timeout_d  = 1'b0;
                    state_d    = S_SET_SHAMT;
                end
            end
            S_SET_SHAMT: begin
                reg_write = 1'b1;
                reg_addr  = dir_q ? REG_LSHIFT : REG_RSHIFT;
                reg_wdata = {27'b0, shamt_q};
                state_d   = S_CLR_FLAG;
            end
            S_CLR_FLAG: begin
                reg_write = 1'b1;
                reg_addr  = REG_FLAG;
                reg_wdata = 32'h0;
                state_d   = S_SEND_DIR;
            end
            S_SEND_DIR: begin
                wrreq = ~wrfull;
                wdata = {(dir_q ? OP_LEFT : OP_RIGHT), 28'h0};
                if (!wrfull) begin
                    state_d = (count_q == '0) ? S_SEND_END : S_SEND_DATA;
                end
            end
            S_SEND_DATA: begin
                src_ready = ~wrfull;
                wrreq     = src_valid & ~wrfull;
                wdata     = {OP_DATA, src_data};
                if (src_valid && !wrfull) begin
                    data_cnt_d = data_cnt_q + CNT_W'(1);
                    if (data_cnt_q == count_q - CNT_W'(1)) begin
                        state_d = S_SEND_END;
                    end
                end
            end
            S_SEND_END: begin
                wrreq = ~wrfull;
                wdata = {OP_END, 28'h0};
                if (!wrfull) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                flag_d     = flag_now;
                // Completion wins over a timeout that expires on the same cycle.
                if (flag_now && (res_cnt_q == count_q)) begin
                    state_d = S_FINISH;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end
            end
            S_FINISH: begin
                done      = 1'b1;
                reg_write = 1'b1;
                reg_addr  = REG_FLAG;
                reg_wdata = 32'h0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_cmd_encoder.sv
// Bench for shift_cmd_encoder: FIFO/register-file models around the DUT, a job table,
// randomized jobs and a reset-mid-job sequence, all checked against job-level expectations.
module tb_shift_cmd_encoder;
    localparam int CNT_W = 16;
    localparam int TMO   = 16;

    typedef struct {
        bit          dir;
        logic [4:0]  sh;
        int          wc;
        int          stall_at;
        int          stall_len;
        bit          flag;
        int          extra;
        int          res_delay;
        bit          rnd;
        bit          fixed;
        logic [31:0] exp_dir_word;
        logic [31:0] exp_sh_addr;
        bit          exp_tmo;
    } job_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             cmd_dir = 1'b0;
    logic [4:0]       shamt = 5'd0;
    logic [CNT_W-1:0] word_count = '0;
    logic             src_valid = 1'b0;
    logic [27:0]      src_data = 28'h0;
    logic             src_ready;
    logic             wrreq;
    logic [31:0]      wdata;
    logic             wrfull = 1'b0;
    logic             rdack;
    logic [31:0]      rdata = 32'h0;
    logic             rdempty = 1'b1;
    logic             res_valid;
    logic [31:0]      res_data;
    logic             reg_write;
    logic [31:0]      reg_addr;
    logic [31:0]      reg_wdata;
    logic [31:0]      reg_rdata;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [2:0]       dbg_state;

    always #5 clk = ~clk;

    shift_cmd_encoder #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd_dir(cmd_dir), .shamt(shamt),
        .word_count(word_count), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .wrreq(wrreq), .wdata(wdata), .wrfull(wrfull),
        .rdack(rdack), .rdata(rdata), .rdempty(rdempty), .res_valid(res_valid),
        .res_data(res_data), .reg_write(reg_write), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .busy(busy), .done(done),
        .timeout(timeout), .dbg_state(dbg_state)
    );

    // Register file and FIFO models
    logic [31:0] regs_m [0:7];
    assign reg_rdata = (reg_addr < 32'd8) ? regs_m[reg_addr[2:0]] : 32'h0;

    logic [27:0] src_q[$];
    logic [31:0] rfifo_q[$];
    logic [31:0] cmd_log[$];
    int          cmd_cyc[$];
    logic [31:0] reg_addr_log[$];
    logic [31:0] reg_data_log[$];
    logic [31:0] res_log[$];
    int          pop_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          viol = 0;
    int          cyc = 0;
    bit          src_rand = 1'b0;
    bit          wrfull_rand = 1'b0;
    int          checks = 0;
    int          failures = 0;

    initial begin
        bit          pend_wr, pend_pop, pend_src;
        logic [31:0] pend_addr, pend_data;
        pend_wr = 0; pend_pop = 0; pend_src = 0; pend_addr = 0; pend_data = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (wrreq) begin
                    if (wrfull) viol++;
                    cmd_log.push_back(wdata);
                    cmd_cyc.push_back(cyc);
                end
                if (reg_write) begin
                    reg_addr_log.push_back(reg_addr);
                    reg_data_log.push_back(reg_wdata);
                    pend_wr = 1; pend_addr = reg_addr; pend_data = reg_wdata;
                end
                if (rdack) begin
                    pend_pop = 1;
                    pop_cyc.push_back(cyc);
                end
                if (res_valid) res_log.push_back(res_data);
                if (src_valid && src_ready) pend_src = 1;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            if (pend_wr && pend_addr < 32'd8) regs_m[pend_addr[2:0]] = pend_data;
            if (pend_pop && rfifo_q.size() > 0) void'(rfifo_q.pop_front());
            if (pend_src && src_q.size() > 0) void'(src_q.pop_front());
            pend_wr = 0; pend_pop = 0; pend_src = 0;
            #1;
            rdempty   = (rfifo_q.size() == 0);
            rdata     = rdempty ? 32'h0 : rfifo_q[0];
            src_valid = (src_q.size() != 0) && (!src_rand || ($urandom_range(0, 3) != 0));
            src_data  = (src_q.size() != 0) ? src_q[0] : 28'h0;
            if (wrfull_rand) wrfull = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, state=%0d", dbg_state);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        cmd_log.delete(); cmd_cyc.delete();
        reg_addr_log.delete(); reg_data_log.delete();
        res_log.delete(); pop_cyc.delete();
        done_cnt = 0; done_cyc = 0; viol = 0;
    endtask

    task automatic check_reset_outputs(input string t);
        chk({t, "_wrreq"}, wrreq, 0);
        chk({t, "_wdata"}, wdata, 0);
        chk({t, "_rdack"}, rdack, 0);
        chk({t, "_res_valid"}, res_valid, 0);
        chk({t, "_reg_write"}, reg_write, 0);
        chk({t, "_reg_addr"}, reg_addr, 4);
        chk({t, "_reg_wdata"}, reg_wdata, 0);
        chk({t, "_src_ready"}, src_ready, 0);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_done"}, done, 0);
        chk({t, "_timeout"}, timeout, 0);
    endtask

    task automatic run_job(input job_t j, input int idx);
        logic [27:0] data[$];
        logic [31:0] exp_cmd[$];
        logic [31:0] exp_res[$];
        logic [31:0] w;
        int          s_cyc, end_cyc, guard, stall_left;
        bit          got_end, stall_used;
        string       t;
        t = $sformatf("j%0d", idx);

        // Job-level expectations: direction word, one data word per source word, end word.
        for (int i = 0; i < j.wc; i++) begin
            if (j.fixed) data.push_back(28'(256 * (i + 1)));
            else data.push_back(28'($urandom));
        end
        exp_cmd.push_back(j.exp_dir_word);
        foreach (data[i]) exp_cmd.push_back({4'h8, data[i]});
        exp_cmd.push_back(32'h4000_0000);
        for (int i = 0; i < j.wc + j.extra; i++) begin
            if (i < j.wc) w = {4'h0, data[i]};
            else w = 32'hE000_0000 + 32'(i);
            exp_res.push_back(j.dir ? (w << j.sh) : (w >> j.sh));
        end

        clear_logs();
        src_rand = j.rnd; wrfull_rand = j.rnd; wrfull = 1'b0;
        foreach (data[i]) src_q.push_back(data[i]);
        cmd_dir = j.dir; shamt = j.sh; word_count = CNT_W'(j.wc);
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
        cmd_dir = ~j.dir; shamt = 5'($urandom); word_count = CNT_W'($urandom);
        chk({t, "_tmo_clear"}, timeout, 0);

        got_end = 0; stall_used = 0; stall_left = 0; guard = 0;
        while (!got_end && guard < 300) begin
            tick();
            guard++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) wrfull = 1'b0;
            end else if (!stall_used && j.stall_len > 0 && cmd_log.size() >= j.stall_at) begin
                wrfull = 1'b1;
                stall_used = 1;
                stall_left = j.stall_len;
            end
            got_end = (cmd_log.size() > 0) && (cmd_log[$] == 32'h4000_0000);
        end
        wrfull_rand = 1'b0; wrfull = 1'b0; src_rand = 1'b0;
        chk({t, "_end_seen"}, got_end, 1);
        end_cyc = (cmd_cyc.size() > 0) ? cmd_cyc[$] : 0;

        if (j.flag) regs_m[4] = 32'h0000_FFFF;
        repeat (j.res_delay) tick();
        foreach (exp_res[i]) rfifo_q.push_back(exp_res[i]);

        guard = 0;
        while (done_cnt == 0 && guard < 100) begin
            tick();
            guard++;
        end
        chk({t, "_done_seen"}, (done_cnt != 0), 1);
        repeat (3) tick();

        chk({t, "_cmd_n"}, cmd_log.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size() && i < cmd_log.size(); i++)
            chk($sformatf("%s_cmd%0d", t, i), cmd_log[i], exp_cmd[i]);
        chk({t, "_reg_n"}, reg_addr_log.size(), 3);
        if (reg_addr_log.size() == 3) begin
            chk({t, "_reg0_addr"}, reg_addr_log[0], j.exp_sh_addr);
            chk({t, "_reg0_data"}, reg_data_log[0], {27'b0, j.sh});
            chk({t, "_reg1_addr"}, reg_addr_log[1], 4);
            chk({t, "_reg1_data"}, reg_data_log[1], 0);
            chk({t, "_reg2_addr"}, reg_addr_log[2], 4);
            chk({t, "_reg2_data"}, reg_data_log[2], 0);
        end
        chk({t, "_res_n"}, res_log.size(), exp_res.size());
        for (int i = 0; i < exp_res.size() && i < res_log.size(); i++)
            chk($sformatf("%s_res%0d", t, i), res_log[i], exp_res[i]);
        chk({t, "_done_cnt"}, done_cnt, 1);
        chk({t, "_full_push"}, viol, 0);
        chk({t, "_timeout"}, timeout, j.exp_tmo);
        chk({t, "_idle"}, busy, 0);
        if (!j.rnd && cmd_cyc.size() > 0)
            chk({t, "_first_lat"}, cmd_cyc[0] - s_cyc, 3);
        if (!j.rnd && j.stall_len == 0 && cmd_cyc.size() > 0)
            chk({t, "_burst_span"}, cmd_cyc[$] - cmd_cyc[0], exp_cmd.size() - 1);
        if (j.exp_tmo)
            chk({t, "_tmo_lat"}, done_cyc - end_cyc, TMO + 1);
        else if (j.wc > 0 && pop_cyc.size() >= j.wc)
            chk({t, "_done_after_res"}, (done_cyc >= pop_cyc[j.wc - 1] + 2), 1);
        src_q.delete();
        rfifo_q.delete();
    endtask

    task automatic reset_test();
        logic [27:0] d[$];
        int          guard, n_cmd, n_reg, n_pop;
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            d.push_back(28'($urandom));
            src_q.push_back(d[i]);
        end
        cmd_dir = 1'b0; shamt = 5'd3; word_count = CNT_W'(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (cmd_log.size() < 2 && guard < 50) begin tick(); guard++; end
        cmd_dir = 1'b1; word_count = CNT_W'(1); start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (cmd_log.size() < 4 && guard < 50) begin tick(); guard++; end
        chk("rst_mid_reached", (cmd_log.size() >= 4), 1);
        chk("rst_busy_reg_n", reg_addr_log.size(), 2);
        if (cmd_log.size() >= 4) begin
            chk("rst_cmd0", cmd_log[0], 32'h1000_0000);
            for (int i = 1; i < 4; i++)
                chk($sformatf("rst_cmd%0d", i), cmd_log[i], {4'h8, d[i - 1]});
        end
        reset = 1'b1;
        rfifo_q.push_back(32'h1234_5678);
        #2;
        check_reset_outputs("rst_mid");
        n_cmd = cmd_log.size(); n_reg = reg_addr_log.size(); n_pop = pop_cyc.size();
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("rst_no_cmd", cmd_log.size(), n_cmd);
        chk("rst_no_reg", reg_addr_log.size(), n_reg);
        chk("rst_no_pop", pop_cyc.size(), n_pop);
        chk("rst_idle", busy, 0);
        src_q.delete();
        rfifo_q.delete();
        regs_m[4] = 32'h0;
        tick();
    endtask

    initial begin
        job_t jobs[6];
        job_t rj;
        for (int i = 0; i < 8; i++) regs_m[i] = 32'h0;
        jobs[0] = '{dir: 1'b0, sh: 5'd4,  wc: 3, stall_at: 0, stall_len: 0, flag: 1'b1, extra: 0,
                    res_delay: 0, rnd: 1'b0, fixed: 1'b1, exp_dir_word: 32'h1000_0000,
                    exp_sh_addr: 32'd2, exp_tmo: 1'b0};
        jobs[1] = '{dir: 1'b1, sh: 5'd2,  wc: 2, stall_at: 2, stall_len: 5, flag: 1'b1, extra: 0,
                    res_delay: 0, rnd: 1'b0, fixed: 1'b0, exp_dir_word: 32'h2000_0000,
                    exp_sh_addr: 32'd3, exp_tmo: 1'b0};
        jobs[2] = '{dir: 1'b0, sh: 5'd7,  wc: 0, stall_at: 0, stall_len: 0, flag: 1'b1, extra: 0,
                    res_delay: 0, rnd: 1'b0, fixed: 1'b0, exp_dir_word: 32'h1000_0000,
                    exp_sh_addr: 32'd2, exp_tmo: 1'b0};
        jobs[3] = '{dir: 1'b1, sh: 5'd1,  wc: 2, stall_at: 0, stall_len: 0, flag: 1'b0, extra: 0,
                    res_delay: 0, rnd: 1'b0, fixed: 1'b0, exp_dir_word: 32'h2000_0000,
                    exp_sh_addr: 32'd3, exp_tmo: 1'b1};
        jobs[4] = '{dir: 1'b0, sh: 5'd9,  wc: 4, stall_at: 0, stall_len: 0, flag: 1'b1, extra: 0,
                    res_delay: 6, rnd: 1'b0, fixed: 1'b0, exp_dir_word: 32'h1000_0000,
                    exp_sh_addr: 32'd2, exp_tmo: 1'b0};
        jobs[5] = '{dir: 1'b1, sh: 5'd31, wc: 3, stall_at: 0, stall_len: 0, flag: 1'b1, extra: 1,
                    res_delay: 0, rnd: 1'b0, fixed: 1'b0, exp_dir_word: 32'h2000_0000,
                    exp_sh_addr: 32'd3, exp_tmo: 1'b0};

        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_job(jobs[i], i);
            if (jobs[i].exp_tmo) begin
                repeat (4) tick();
                chk("tmo_hold", timeout, 1);
            end
        end

        reset_test();

        for (int i = 0; i < 6; i++) begin
            rj.dir          = 1'($urandom_range(0, 1));
            rj.sh           = 5'($urandom);
            rj.wc           = $urandom_range(0, 6);
            rj.stall_at     = 0;
            rj.stall_len    = 0;
            rj.flag         = 1'b1;
            rj.extra        = 0;
            rj.res_delay    = $urandom_range(0, 3);
            rj.rnd          = 1'b1;
            rj.fixed        = 1'b0;
            rj.exp_dir_word = rj.dir ? 32'h2000_0000 : 32'h1000_0000;
            rj.exp_sh_addr  = rj.dir ? 32'd3 : 32'd2;
            rj.exp_tmo      = 1'b0;
            run_job(rj, 10 + i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
